// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity mode constants and FSM state encoding for the UART transmitter
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period divider, tick on the last clock of each CPB-clock period
module uart_baud_tick #(
  parameter int CPB = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  if (CPB == 1) begin : g_const
    // Every clock is a bit boundary, so no counter state is needed.
    logic w_unused;
    assign w_unused = clk ^ rst_n ^ clr;
    assign tick     = 1'b1;
  end else begin : g_cnt
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (clr || r_cnt == LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign tick = (r_cnt == LAST);
  end

endmodule

// File: rtl/uart_tx_gen.sv
// rtl/uart_tx_gen.sv - parameterised UART frame transmitter with optional parity and line inversion
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int DW     = 8,
  parameter int CPB    = 1,
  parameter int PARITY = 0,
  parameter int STOP   = 1,
  parameter int INVERT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          send,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          out
);

  if (DW < 5 || DW > 9) begin : g_bad_dw
    $fatal(1, "uart_tx_gen: DW must be 5..9");
  end
  if (CPB < 1 || CPB > 65535) begin : g_bad_cpb
    $fatal(1, "uart_tx_gen: CPB must be 1..65535");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $fatal(1, "uart_tx_gen: PARITY must be 0, 1 or 2");
  end
  if (STOP < 1 || STOP > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_gen: STOP must be 1 or 2");
  end
  if (INVERT < 0 || INVERT > 1) begin : g_bad_inv
    $fatal(1, "uart_tx_gen: INVERT must be 0 or 1");
  end

  localparam logic [3:0] LAST_BIT  = 4'(DW - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP - 1);
  localparam logic       HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic       PAR_FLIP  = (PARITY == PAR_ODD);
  localparam logic       LINE_INV  = (INVERT != 0);

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_shift;
  logic          r_par;
  logic [3:0]    r_cnt;
  logic          w_tick;
  logic          w_clr;
  logic          w_load;
  logic          w_line;

  assign w_clr = (r_state == ST_IDLE);

  uart_baud_tick #(.CPB(CPB)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_shift <= din;
        r_par   <= ^din;
        r_cnt   <= '0;
      end else if (w_tick) begin
        // r_cnt indexes data bits in DATA and stop periods in STOP.
        if (r_state == ST_DATA) begin
          r_shift <= r_shift >> 1;
          r_cnt   <= (r_cnt == LAST_BIT) ? 4'd0 : r_cnt + 4'd1;
        end else if (r_state == ST_STOP) begin
          r_cnt   <= (r_cnt == LAST_STOP) ? 4'd0 : r_cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_line = 1'b1;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (send) begin
          w_next = ST_START;
          w_load = 1'b1;
        end
      end
      ST_START: begin
        w_line = 1'b0;
        if (w_tick) w_next = ST_DATA;
      end
      ST_DATA: begin
        w_line = r_shift[0];
        if (w_tick && r_cnt == LAST_BIT) w_next = HAS_PAR ? ST_PAR : ST_STOP;
      end
      ST_PAR: begin
        w_line = r_par ^ PAR_FLIP;
        if (w_tick) w_next = ST_STOP;
      end
      ST_STOP: begin
        w_line = 1'b1;
        if (w_tick && r_cnt == LAST_STOP) begin
          done = 1'b1;
          if (send) begin
            w_next = ST_START;
            w_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
        busy   = 1'b0;
      end
    endcase
    out = w_line ^ LINE_INV;
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// tb/tb_uart_tx_gen.sv - directed and randomised checks of uart_tx_gen across four configurations
module tb_uart_tx_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send0, send1, send2, send3;
  logic [7:0] din0, din1, din2;
  logic [6:0] din3;
  logic       busy0, done0, out0;
  logic       busy1, done1, out1;
  logic       busy2, done2, out2;
  logic       busy3, done3, out3;
  int         vectors = 0;
  int         errors  = 0;

  always #5 clk = ~clk;

  uart_tx_gen u0 (
    .clk(clk), .rst_n(rst_n), .send(send0), .din(din0),
    .busy(busy0), .done(done0), .out(out0)
  );
  uart_tx_gen #(.DW(8), .CPB(4), .PARITY(1), .STOP(2), .INVERT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .send(send1), .din(din1),
    .busy(busy1), .done(done1), .out(out1)
  );
  uart_tx_gen #(.PARITY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .send(send2), .din(din2),
    .busy(busy2), .done(done2), .out(out2)
  );
  uart_tx_gen #(.DW(7), .CPB(3)) u3 (
    .clk(clk), .rst_n(rst_n), .send(send3), .din(din3),
    .busy(busy3), .done(done3), .out(out3)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    send0 = 1'b0; send1 = 1'b0; send2 = 1'b0; send3 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    #2;
    vectors++; if (out0 !== 1'b0) begin errors++; $display("FAIL reset_out0 got %b exp 0", out0); end
    vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b exp 0", done0); end
    vectors++; if (out1 !== 1'b1) begin errors++; $display("FAIL reset_out1 got %b exp 1", out1); end
    vectors++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    vectors++; if (out2 !== 1'b0) begin errors++; $display("FAIL reset_out2 got %b exp 0", out2); end
    vectors++; if (out3 !== 1'b0) begin errors++; $display("FAIL reset_out3 got %b exp 0", out3); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL post_reset_busy0 got %b exp 0", busy0); end
  endtask

  task automatic test_basic();
    logic [9:0] exp_out;
    exp_out = 10'b1011010100;
    din0 = 8'hA9; send0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      send0 = 1'b0;
      if (c <= 10) begin
        vectors++; if (out0 !== exp_out[10-c]) begin errors++; $display("FAIL basic_out c=%0d got %b exp %b", c, out0, exp_out[10-c]); end
        vectors++; if (done0 !== (c == 10)) begin errors++; $display("FAIL basic_done c=%0d got %b exp %b", c, done0, (c == 10)); end
        vectors++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy c=%0d got %b exp 1", c, busy0); end
      end else begin
        vectors++; if (out0 !== 1'b0) begin errors++; $display("FAIL basic_idle_out c=%0d got %b exp 0", c, out0); end
        vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL basic_idle_flags c=%0d got busy=%b done=%b exp 0/0", c, busy0, done0); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       s [1:20];
    logic       d [1:20];
    logic [7:0] b1, b2;
    int         dones;
    dones = 0;
    din0 = 8'hA9; send0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      s[c] = out0; d[c] = done0;
      if (done0 === 1'b1) dones++;
      if (c == 10) din0 = 8'hCA;
      if (c == 12) begin din0 = 8'h00; send0 = 1'b0; end
    end
    for (int i = 0; i < 8; i++) begin
      b1[i] = ~s[2+i];
      b2[i] = ~s[12+i];
    end
    vectors++; if (s[11] !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got %b exp 1", s[11]); end
    vectors++; if (b1 !== 8'hA9) begin errors++; $display("FAIL b2b_byte1 got %h exp a9", b1); end
    vectors++; if (b2 !== 8'hCA) begin errors++; $display("FAIL b2b_byte2 got %h exp ca", b2); end
    vectors++; if (dones != 2 || d[10] !== 1'b1 || d[20] !== 1'b1) begin errors++; $display("FAIL b2b_done got count=%0d d10=%b d20=%b exp 2/1/1", dones, d[10], d[20]); end
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy0); end
  endtask

  task automatic test_parity_stop();
    logic [7:0]  dins [2];
    logic [11:0] pats [2];
    dins[0] = 8'h03; pats[0] = 12'b011000000011;
    dins[1] = 8'h01; pats[1] = 12'b010000000111;
    for (int v = 0; v < 2; v++) begin
      din1 = dins[v]; send1 = 1'b1;
      for (int c = 1; c <= 49; c++) begin
        @(negedge clk);
        send1 = 1'b0;
        if (c <= 48) begin
          vectors++; if (out1 !== pats[v][11-(c-1)/4]) begin errors++; $display("FAIL par_out v=%0d c=%0d got %b exp %b", v, c, out1, pats[v][11-(c-1)/4]); end
          vectors++; if (done1 !== (c == 48)) begin errors++; $display("FAIL par_done v=%0d c=%0d got %b exp %b", v, c, done1, (c == 48)); end
        end else begin
          vectors++; if (out1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL par_idle v=%0d got out=%b busy=%b exp 1/0", v, out1, busy1); end
        end
      end
    end
  endtask

  task automatic test_odd_parity();
    logic [7:0]  dins [2];
    logic [10:0] pats [2];
    dins[0] = 8'h01; pats[0] = 11'b10111111110;
    dins[1] = 8'h03; pats[1] = 11'b10011111100;
    for (int v = 0; v < 2; v++) begin
      din2 = dins[v]; send2 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        send2 = 1'b0;
        if (c <= 11) begin
          vectors++; if (out2 !== pats[v][11-c]) begin errors++; $display("FAIL odd_out v=%0d c=%0d got %b exp %b", v, c, out2, pats[v][11-c]); end
          vectors++; if (done2 !== (c == 11)) begin errors++; $display("FAIL odd_done v=%0d c=%0d got %b exp %b", v, c, done2, (c == 11)); end
        end else begin
          vectors++; if (busy2 !== 1'b0) begin errors++; $display("FAIL odd_idle v=%0d got %b exp 0", v, busy2); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic       s [1:10];
    logic       d [1:10];
    logic [7:0] b;
    int         dones;
    din0 = 8'hA9; send0 = 1'b1;
    @(negedge clk);
    send0 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (out0 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL rst_pre got out=%b busy=%b exp 1/1", out0, busy0); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out0 !== 1'b0) begin errors++; $display("FAIL rst_async_out got %b exp 0", out0); end
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL rst_async_flags got busy=%b done=%b exp 0/0", busy0, done0); end
    @(negedge clk);
    rst_n = 1'b1; din0 = 8'h3C; send0 = 1'b1;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      send0 = 1'b0;
      s[c] = out0; d[c] = done0;
      if (done0 === 1'b1) dones++;
    end
    for (int i = 0; i < 8; i++) b[i] = ~s[2+i];
    vectors++; if (s[1] !== 1'b1) begin errors++; $display("FAIL rst_first_start got %b exp 1", s[1]); end
    vectors++; if (b !== 8'h3C) begin errors++; $display("FAIL rst_new_byte got %h exp 3c", b); end
    vectors++; if (dones != 1 || d[10] !== 1'b1) begin errors++; $display("FAIL rst_new_done got count=%0d d10=%b exp 1/1", dones, d[10]); end
  endtask

  task automatic test_random();
    logic [6:0] exp_q [$];
    logic [6:0] cur, got, expb;
    logic       st, sp, last_d;
    int         dn;
    cur = 7'($urandom_range(0, 127));
    exp_q.push_back(cur);
    din3 = cur; send3 = 1'b1;
    for (int f = 0; f < 200; f++) begin
      dn = 0; got = '0; st = 1'b0; sp = 1'b1; last_d = 1'b0;
      for (int c = 1; c <= 27; c++) begin
        @(negedge clk);
        if (done3 === 1'b1) dn++;
        if (c == 2) st = out3;
        if (c >= 5 && c <= 23 && (c % 3) == 2) got[(c-5)/3] = ~out3;
        if (c == 26) sp = out3;
        if (c == 27) last_d = done3;
        if (f == 199 && c == 1) send3 = 1'b0;
        if (c == 27 && f < 199) begin
          cur = 7'($urandom_range(0, 127));
          exp_q.push_back(cur);
          din3 = cur;
        end
      end
      expb = exp_q.pop_front();
      vectors++; if (got !== expb) begin errors++; $display("FAIL rand_byte f=%0d got %h exp %h", f, got, expb); end
      vectors++; if (st !== 1'b1 || sp !== 1'b0) begin errors++; $display("FAIL rand_framing f=%0d got start=%b stop=%b exp 1/0", f, st, sp); end
      vectors++; if (dn != 1 || last_d !== 1'b1) begin errors++; $display("FAIL rand_done f=%0d got count=%0d last=%b exp 1/1", f, dn, last_d); end
    end
    @(negedge clk);
    vectors++; if (busy3 !== 1'b0 || out3 !== 1'b0) begin errors++; $display("FAIL rand_idle got busy=%b out=%b exp 0/0", busy3, out3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity_stop();
    test_odd_parity();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
